// File: rtl/iir_coef_loader.sv
// iir_coef_loader
//   Configuration front end for the cascaded biquad IIR filter. A serial
//   valid/ready stream carries one header beat (filter order in [3:0])
//   followed by 5*order coefficient beats into shadow registers. A good frame
//   is committed to the active coefficient bus on the next sample strobe. The
//   filter is then held in reset for FLUSH_CYCLES cycles so it never runs on a
//   half-loaded set or on stale state.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   cfg_valid      config beat valid
//   cfg_ready      loader can accept a beat
//   cfg_data       header (order in [3:0]) or coefficient word
//   cfg_last       final beat of a frame
//   sample_strobe  one-cycle pulse at each filter input sample
//   coef_bus       active coefficients, slot k at [k*DW +: DW]
//                  (slot order per section: b0,b1,b2,a1,a2)
//   order_out      active filter order, 0 = none
//   filt_rst_n     active-low reset to the filter cascade
//   busy           loader is not idle
//   err            sticky frame error, cleared by a successful commit

module iir_coef_loader #(
    parameter int DW           = 16,
    parameter int MAX_ORDER    = 3,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DW-1:0]             cfg_data,
    input  logic                      cfg_last,
    input  logic                      sample_strobe,
    output logic [5*MAX_ORDER*DW-1:0] coef_bus,
    output logic [3:0]                order_out,
    output logic                      filt_rst_n,
    output logic                      busy,
    output logic                      err
);

    localparam int SLOTS = 5 * MAX_ORDER;
    localparam int CW    = $clog2(SLOTS + 1);
    localparam int FW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]    state;
    logic [3:0]    ord;
    logic [CW-1:0] need;
    logic [CW-1:0] cnt;
    logic [FW-1:0] fcnt;
    logic [DW-1:0] shadow [SLOTS];

    logic [3:0]    hdr_ord;
    logic          hdr_ok;
    logic          accept;
    logic          at_end;

    assign hdr_ord = cfg_data[3:0];
    assign hdr_ok  = (hdr_ord != 4'd0) && (hdr_ord <= 4'(MAX_ORDER));

    // Ready is gated by reset directly so the source sees ready=0 for the
    // whole time reset is held, and ready=1 as soon as it is released.
    assign cfg_ready = !reset && ((state == S_IDLE) || (state == S_LOAD) || (state == S_DRAIN));
    assign accept    = cfg_valid && cfg_ready;

    // The beat at index need-1 is the one that must carry last.
    assign at_end = (cnt == need - CW'(1));
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ord        <= '0;
            need       <= '0;
            cnt        <= '0;
            fcnt       <= '0;
            coef_bus   <= '0;
            order_out  <= '0;
            filt_rst_n <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ord  <= hdr_ord;
                        need <= CW'(hdr_ord) * CW'(5);
                        cnt  <= '0;
                        if (hdr_ok && !cfg_last) begin
                            state <= S_LOAD;
                        end else begin
                            // A bad header ending the frame leaves nothing to
                            // drain; otherwise swallow the rest of the frame.
                            err   <= 1'b1;
                            state <= cfg_last ? S_IDLE : S_DRAIN;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        shadow[cnt] <= cfg_data;
                        cnt         <= cnt + CW'(1);
                        if (cfg_last) begin
                            if (at_end) begin
                                state <= S_WAIT;
                            end else begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else if (at_end) begin
                            err   <= 1'b1;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept && cfg_last) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Commit on a sample boundary: slots beyond the new order
                    // are zeroed so unused sections see a null filter.
                    if (sample_strobe) begin
                        for (int k = 0; k < SLOTS; k++) begin
                            coef_bus[k*DW +: DW] <= (k < int'(need)) ? shadow[k] : '0;
                        end
                        order_out  <= ord;
                        filt_rst_n <= 1'b0;
                        fcnt       <= FW'(FLUSH_CYCLES - 1);
                        err        <= 1'b0;
                        state      <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (fcnt == '0) begin
                        filt_rst_n <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
